dec_64b: RTL and testbench
==========================

# dec_64b

Index-to-mask decoder: the inverse of the 64-bit priority encoder in the H.266 encoder utilities. It accepts a burst of 6-bit bit indices, expands each to a 64-bit one-hot word, and OR-accumulates them into a 64-bit mask. The completed mask is presented for one cycle, together with a population count and a duplicate flag. It is used to rebuild significance and coefficient-position masks that the encoder side compressed into index lists.

## Interface
Parameters: none. All widths are fixed: 6-bit index, 64-bit mask, 7-bit count.

Ports:
- clk_i  input  1  clock, rising edge
- rst_n_i  input  1  reset, asynchronous, active-low
- init_i  input  1  start a new burst; clears the accumulator
- valid_i  input  1  data_i holds a valid index this cycle
- last_i  input  1  final index of the burst; sampled only with valid_i
- data_i  input  6  bit index 0..63; bits [5:3] select the bank, [2:0] select the bit
- busy_o  output  1  high while in ACC
- done_o  output  1  one-cycle pulse: mask complete
- data_o  output  64  completed mask; nonzero only while done_o=1
- cnt_o  output  7  number of distinct bits set (0..64); valid only while done_o=1
- dup_o  output  1  some index repeated in the burst; valid only while done_o=1

## Operation
- Two-state FSM: IDLE, ACC. Reset state is IDLE.
- Internal registers:
  - mask_r[63:0]
  - cnt_r[6:0]
  - dup_r
- IDLE:
  - valid_i and last_i are ignored.
  - init_i=1: clear mask_r, cnt_r and dup_r, then go to ACC.
- ACC:
  - busy_o=1.
  - When valid_i=1 and init_i=0, compute oh = 1<<data_i.
  - If (mask_r & oh) is nonzero, set dup_r=1 and leave cnt_r unchanged.
  - Otherwise, cnt_r increments by 1.
  - mask_r becomes mask_r | oh.
- ACC with valid_i=1, last_i=1, init_i=0:
  - The final beat is included.
  - The next cycle, done_o=1, data_o=mask_r|oh, cnt_o=final count, dup_o=final flag.
  - The FSM returns to IDLE.
- ACC with init_i=1, restart:
  - Clears mask_r, cnt_r and dup_r, and stays in ACC.
  - valid_i and last_i in the same cycle are discarded; init_i has priority.
  - No done_o is produced for the abandoned burst.
- ACC with valid_i=0: state and accumulator hold.
- Count arithmetic: 7-bit, no saturation needed, since at most 64 distinct bits can be set. 64 distinct indices give cnt_o=64 (7'h40).
- Outputs outside the done cycle: data_o=0, cnt_o=0, dup_o=0, done_o=0.

## Timing
- Reset values: every output 0, FSM in IDLE, all internal registers 0.
- Assertion of rst_n_i takes effect immediately and asynchronously. Reset mid-burst discards the burst with no done_o.
- Latency: done_o rises 1 cycle after the clock edge that accepts the last beat. It is high for exactly 1 cycle.
- Throughput: 1 index per cycle.
- The earliest next init_i is the done_o cycle itself. FSM is already in IDLE then, so the init is accepted, and the next burst may begin the cycle after.
- Minimum burst: init_i followed by a single valid_i+last_i beat. done_o arrives on the 3rd cycle counting the init cycle as cycle 1.
- There is no backpressure. done_o is not held; the consumer must capture data_o during the pulse.
- All outputs are driven directly from registers; there is no combinational input-to-output path.

## Structure
- Package utils_pkg holds:
  - IDX_W=6, MASK_W=64, CNT_W=7
  - the FSM state enum (IDLE, ACC) as a typedef
- One sub-module, dec_8b: combinational 3-to-8 one-hot decoder.
  - Instantiate twice: bank decode of data_i[5:3], and bit decode of data_i[2:0].
  - Byte k of oh = bank_oh[k] ? bit_oh : 8'h00.
- The rest is a single always_ff for the FSM, accumulator and output registers, plus the duplicate test (|(mask_r & oh)).

## Test plan
- Reset, then init_i, then indices 0, 63, 9 with last_i on 9 -> one-cycle done_o; data_o=64'h8000_0000_0000_0201, cnt_o=3, dup_o=0; all outputs 0 the following cycle.
- Burst 5, 5, 12 (last) -> data_o=64'h0000_0000_0000_1020, cnt_o=2, dup_o=1.
- Burst of all 64 indices 0..63 back-to-back with no gaps -> data_o=all ones, cnt_o=64; done_o exactly 1 cycle after the last beat.
- valid_i gaps mid-burst, then init_i with valid_i=1, data_i=7 while in ACC, then 3 (last) -> data_o=64'h8, cnt_o=1; index 7 and the earlier beats are discarded.
- valid_i/last_i pulses in IDLE with no init_i -> no done_o and busy_o=0. Next, init_i issued in the done_o cycle of a previous burst, followed by a burst -> accepted, with a correct second mask.
- rst_n_i asserted asynchronously mid-burst, off a clock edge -> outputs go to 0 immediately; after release, no done_o until a new init_i burst completes.

Source files
------------

// File: rtl/utils_pkg.sv
// utils_pkg: shared widths and FSM state type for the index-to-mask decoder
package utils_pkg;
    localparam int IDX_W  = 6;
    localparam int MASK_W = 64;
    localparam int CNT_W  = 7;
    typedef enum logic {IDLE, ACC} state_e;
endpackage

// File: rtl/dec_8b.sv
// dec_8b: combinational 3-to-8 one-hot decoder
//   sel_i : 3-bit select
//   oh_o  : 8-bit one-hot output, bit sel_i set
module dec_8b (
    input  logic [2:0] sel_i,
    output logic [7:0] oh_o
);
    assign oh_o = 8'd1 << sel_i;
endmodule

// File: rtl/dec_64b.sv
// dec_64b: accumulates a burst of 6-bit indices into a 64-bit mask with popcount and duplicate flag
//   clk_i, rst_n_i : clock, async active-low reset
//   init_i         : start/restart a burst (clears accumulator, has priority)
//   valid_i        : data_i carries an index
//   last_i         : final index of the burst (with valid_i)
//   data_i         : index, [5:3] bank, [2:0] bit
//   busy_o         : burst in progress
//   done_o         : one-cycle pulse with data_o/cnt_o/dup_o valid, all zero otherwise
module dec_64b
    import utils_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              init_i,
    input  logic              valid_i,
    input  logic              last_i,
    input  logic [IDX_W-1:0]  data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [MASK_W-1:0] data_o,
    output logic [CNT_W-1:0]  cnt_o,
    output logic              dup_o
);
    state_e            state_r;
    logic [MASK_W-1:0] mask_r, oh, mask_nx;
    logic [CNT_W-1:0]  cnt_r, cnt_nx;
    logic              dup_r, dup_nx, hit;
    logic [7:0]        bank_oh, bit_oh;

    dec_8b u_bank (.sel_i(data_i[5:3]), .oh_o(bank_oh));
    dec_8b u_bit  (.sel_i(data_i[2:0]), .oh_o(bit_oh));

    for (genvar k = 0; k < 8; k++) begin : g_byte
        assign oh[8*k +: 8] = bank_oh[k] ? bit_oh : 8'h00;
    end

    // A bit already present marks a duplicate and does not add to the count
    assign hit     = |(mask_r & oh);
    assign mask_nx = mask_r | oh;
    assign cnt_nx  = hit ? cnt_r : cnt_r + 7'd1;
    assign dup_nx  = dup_r | hit;
    assign busy_o  = (state_r == ACC);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= IDLE;
            mask_r  <= '0;
            cnt_r   <= '0;
            dup_r   <= 1'b0;
            done_o  <= 1'b0;
            data_o  <= '0;
            cnt_o   <= '0;
            dup_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            data_o <= '0;
            cnt_o  <= '0;
            dup_o  <= 1'b0;
            if (init_i) begin
                state_r <= ACC;
                mask_r  <= '0;
                cnt_r   <= '0;
                dup_r   <= 1'b0;
            end else if (state_r == ACC && valid_i) begin
                mask_r <= mask_nx;
                cnt_r  <= cnt_nx;
                dup_r  <= dup_nx;
                if (last_i) begin
                    state_r <= IDLE;
                    done_o  <= 1'b1;
                    data_o  <= mask_nx;
                    cnt_o   <= cnt_nx;
                    dup_o   <= dup_nx;
                end
            end
        end
    end
endmodule

// File: tb/tb_dec_64b.sv
// tb_dec_64b: directed and randomized checks of dec_64b against a set-based reference model
module tb_dec_64b;
    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        init_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        last_i = 1'b0;
    logic [5:0]  data_i = '0;
    logic        busy_o, done_o, dup_o;
    logic [63:0] data_o;
    logic [6:0]  cnt_o;

    int n_chk = 0;
    int n_fail = 0;

    bit ref_set [64];
    int ref_cnt;
    bit ref_dup;
    bit in_acc = 0;

    dec_64b dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .init_i(init_i), .valid_i(valid_i),
        .last_i(last_i), .data_i(data_i), .busy_o(busy_o), .done_o(done_o),
        .data_o(data_o), .cnt_o(cnt_o), .dup_o(dup_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mask();
        logic [63:0] m = '0;
        for (int i = 0; i < 64; i++) m[i] = ref_set[i];
        return m;
    endfunction

    task automatic clear_ref();
        for (int i = 0; i < 64; i++) ref_set[i] = 0;
        ref_cnt = 0;
        ref_dup = 0;
    endtask

    // Drives one cycle, updates the model, then checks the outputs after the edge
    task automatic step(input logic ini, input logic v, input logic l, input logic [5:0] d);
        bit fin = 0;
        init_i = ini; valid_i = v; last_i = l; data_i = d;
        if (ini) begin
            clear_ref();
            in_acc = 1;
        end else if (in_acc && v) begin
            if (ref_set[d]) ref_dup = 1;
            else ref_cnt++;
            ref_set[d] = 1;
            if (l) begin
                fin = 1;
                in_acc = 0;
            end
        end
        @(posedge clk_i); #1;
        init_i = 0; valid_i = 0; last_i = 0;
        chk("done", done_o, fin);
        chk("busy", busy_o, in_acc);
        chk("data", data_o, fin ? ref_mask() : 64'h0);
        chk("cnt", cnt_o, fin ? ref_cnt : 0);
        chk("dup", dup_o, fin ? ref_dup : 0);
    endtask

    initial begin
        int len;
        clear_ref();
        #12;
        chk("rst_done", done_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_cnt", cnt_o, 0);
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        step(1, 0, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 63); step(0, 1, 1, 9);
        chk("t1_mask", data_o, 64'h8000_0000_0000_0201);
        chk("t1_cnt", cnt_o, 3);
        step(0, 0, 0, 0);

        step(1, 0, 0, 0); step(0, 1, 0, 5); step(0, 1, 0, 5); step(0, 1, 1, 12);
        chk("t2_mask", data_o, 64'h0000_0000_0000_1020);
        chk("t2_dup", dup_o, 1);

        step(1, 0, 0, 0);
        for (int i = 0; i < 64; i++) step(0, 1, i == 63, 6'(i));
        chk("t3_mask", data_o, {64{1'b1}});
        chk("t3_cnt", cnt_o, 64);

        step(1, 0, 0, 0); step(0, 1, 0, 4); step(0, 0, 0, 0); step(0, 1, 0, 6); step(0, 0, 0, 0);
        step(1, 1, 0, 7); step(0, 1, 1, 3);
        chk("t4_mask", data_o, 64'h8);

        step(0, 1, 1, 2); step(0, 1, 0, 9); step(0, 0, 1, 1);
        step(1, 0, 0, 0); step(0, 1, 1, 17);
        step(1, 0, 0, 0); step(0, 1, 0, 40); step(0, 1, 1, 41);
        chk("t5_mask", data_o, 64'h0000_0300_0000_0000);

        // async reset during a done pulse, off the clock edge
        step(1, 0, 0, 0); step(0, 1, 1, 30);
        #2 rst_n_i = 1'b0;
        #1;
        chk("arst_done", done_o, 0);
        chk("arst_data", data_o, 0);
        #3 rst_n_i = 1'b1;
        in_acc = 0;
        @(posedge clk_i); #1;
        // async reset mid-burst
        step(1, 0, 0, 0); step(0, 1, 0, 11);
        #2 rst_n_i = 1'b0;
        #1;
        chk("arst_busy", busy_o, 0);
        #3 rst_n_i = 1'b1;
        in_acc = 0;
        @(posedge clk_i); #1;
        step(0, 1, 1, 12); step(0, 1, 0, 13);

        for (int b = 0; b < 25; b++) begin
            if ($urandom_range(0, 3) == 0) step(0, 1, 1, 6'($urandom));
            step(1, 0, 0, 0);
            len = $urandom_range(1, 24);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 3) == 0) step(0, 0, 1, 6'($urandom));
                if ($urandom_range(0, 15) == 0) step(1, 1, 0, 6'($urandom));
                step(0, 1, j == len - 1, (b % 2) ? 6'($urandom_range(0, 7)) : 6'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
